// File: rtl/team_06_tremolo.sv
`default_nettype none
// ============================================================================
//  Module   : team_06_tremolo
//  Purpose  : Triangle-LFO amplitude modulator with a two-stage sample pipeline.
//  Revision : 1.0 - initial release
// ============================================================================
module team_06_tremolo #(
  parameter int LFO_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clkdiv,
  input  logic             en,
  input  logic [3:0]       depth,
  input  logic [15:0]      sample_in,
  input  logic             sample_valid_in,
  output logic [15:0]      sample_out,
  output logic             sample_valid_out,
  output logic [LFO_W-1:0] lfo_out
);

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_t;

  localparam logic [LFO_W-1:0] c_lfo_max  = {LFO_W{1'b1}};
  localparam logic [LFO_W-1:0] c_lfo_zero = {LFO_W{1'b0}};
  localparam logic [LFO_W-1:0] c_lfo_one  = {{(LFO_W-1){1'b0}}, 1'b1};
  localparam logic [LFO_W:0]   c_unity    = {1'b1, {LFO_W{1'b0}}};

  logic                     r_clkdiv_q;
  logic                     w_tick;
  logic [LFO_W-1:0]         r_lfo;
  dir_t                     r_dir;

  logic [LFO_W-1:0]         w_headroom;
  logic [LFO_W+3:0]         w_scaled;
  logic [LFO_W:0]           w_atten;
  logic [LFO_W:0]           w_gain;

  logic [15:0]              r_s1_sample;
  logic [LFO_W:0]           r_s1_gain;
  logic                     r_s1_valid;

  logic signed [LFO_W+17:0] w_mul_a;
  logic signed [LFO_W+17:0] w_mul_b;
  logic signed [LFO_W+17:0] w_prod;

  assign w_tick = clkdiv & ~r_clkdiv_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clkdiv_q <= 1'b0;
    end else begin
      r_clkdiv_q <= clkdiv;
    end
  end

  // Bypass parks the LFO at its peak so tremolo restarts from unity gain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfo <= c_lfo_max;
      r_dir <= DIR_DOWN;
    end else if (!en) begin
      r_lfo <= c_lfo_max;
      r_dir <= DIR_DOWN;
    end else if (w_tick) begin
      if (r_dir == DIR_DOWN) begin
        if (r_lfo == c_lfo_zero) begin
          r_dir <= DIR_UP;
          r_lfo <= c_lfo_one;
        end else begin
          r_lfo <= r_lfo - c_lfo_one;
        end
      end else begin
        if (r_lfo == c_lfo_max) begin
          r_dir <= DIR_DOWN;
          r_lfo <= c_lfo_max - c_lfo_one;
        end else begin
          r_lfo <= r_lfo + c_lfo_one;
        end
      end
    end
  end

  assign lfo_out = r_lfo;

  // Gain is unity at the LFO peak and dips by depth/16 of full scale at the trough.
  assign w_headroom = c_lfo_max - r_lfo;
  assign w_scaled   = {{LFO_W{1'b0}}, depth} * {4'd0, w_headroom};
  assign w_atten    = (LFO_W+1)'(w_scaled >> 4);
  assign w_gain     = en ? (c_unity - w_atten) : c_unity;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_sample <= 16'd0;
      r_s1_gain   <= {(LFO_W+1){1'b0}};
      r_s1_valid  <= 1'b0;
    end else begin
      r_s1_valid <= sample_valid_in;
      if (sample_valid_in) begin
        r_s1_sample <= sample_in;
        r_s1_gain   <= w_gain;
      end
    end
  end

  assign w_mul_a = {{(LFO_W+2){r_s1_sample[15]}}, r_s1_sample};
  assign w_mul_b = {17'd0, r_s1_gain};
  assign w_prod  = w_mul_a * w_mul_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_out       <= 16'd0;
      sample_valid_out <= 1'b0;
    end else begin
      sample_valid_out <= r_s1_valid;
      if (r_s1_valid) begin
        sample_out <= 16'(w_prod >>> LFO_W);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_team_06_tremolo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_team_06_tremolo
//  Purpose  : Directed self-checking bench for team_06_tremolo.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_team_06_tremolo;

  logic        clk = 1'b0;
  logic        rst;
  logic        clkdiv;
  logic        en;
  logic [3:0]  depth;
  logic [15:0] sample_in;
  logic        sample_valid_in;
  logic [15:0] sample_out;
  logic        sample_valid_out;
  logic [7:0]  lfo_out;

  int checks = 0;
  int errors = 0;

  team_06_tremolo #(.LFO_W(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .clkdiv           (clkdiv),
    .en               (en),
    .depth            (depth),
    .sample_in        (sample_in),
    .sample_valid_in  (sample_valid_in),
    .sample_out       (sample_out),
    .sample_valid_out (sample_valid_out),
    .lfo_out          (lfo_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk) clkdiv = 1'b1;
    @(negedge clk) clkdiv = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  // Leaves the caller at the negedge where the sample's result is visible.
  task automatic drive_sample(input logic [15:0] s);
    @(negedge clk);
    sample_in       = s;
    sample_valid_in = 1'b1;
    @(negedge clk) sample_valid_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    checks++; if (sample_out !== 16'h0000) begin errors++; $display("FAIL reset_out: got %h want 0000", sample_out); end
    checks++; if (sample_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", sample_valid_out); end
    checks++; if (lfo_out !== 8'd255) begin errors++; $display("FAIL reset_lfo: got %0d want 255", lfo_out); end
    @(negedge clk) rst = 1'b0;
    en = 1'b1; depth = 4'd0;
    tick();
    drive_sample(16'h1234);
    checks++; if (sample_out !== 16'h1234) begin errors++; $display("FAIL pre_reset_out: got %h want 1234", sample_out); end
    // Put a sample in flight, then hit reset asynchronously mid-cycle.
    @(negedge clk);
    sample_in = 16'h5678; sample_valid_in = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    sample_valid_in = 1'b0;
    #1;
    checks++; if (sample_out !== 16'h0000) begin errors++; $display("FAIL async_reset_out: got %h want 0000", sample_out); end
    checks++; if (sample_valid_out !== 1'b0) begin errors++; $display("FAIL async_reset_valid: got %b want 0", sample_valid_out); end
    checks++; if (lfo_out !== 8'd255) begin errors++; $display("FAIL async_reset_lfo: got %0d want 255", lfo_out); end
    repeat (3) @(negedge clk);
    checks++; if (sample_out !== 16'h0000 || lfo_out !== 8'd255) begin errors++; $display("FAIL reset_hold: got out=%h lfo=%0d want 0000/255", sample_out, lfo_out); end
    rst = 1'b0; en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (sample_valid_out !== 1'b0) begin errors++; $display("FAIL stale_valid[%0d]: got %b want 0", i, sample_valid_out); end
    end
  endtask

  task automatic test_bypass();
    en = 1'b0; depth = 4'd15;
    @(negedge clk);
    sample_in = 16'h4000; sample_valid_in = 1'b1; clkdiv = 1'b1;
    @(negedge clk);
    sample_valid_in = 1'b0; clkdiv = 1'b0;
    checks++; if (sample_valid_out !== 1'b0) begin errors++; $display("FAIL bypass_lat1_valid: got %b want 0", sample_valid_out); end
    @(negedge clk);
    clkdiv = 1'b1;
    checks++; if (sample_valid_out !== 1'b1) begin errors++; $display("FAIL bypass_valid: got %b want 1", sample_valid_out); end
    checks++; if (sample_out !== 16'h4000) begin errors++; $display("FAIL bypass_out: got %h want 4000", sample_out); end
    @(negedge clk);
    clkdiv = 1'b0;
    checks++; if (sample_valid_out !== 1'b0 || sample_out !== 16'h4000) begin errors++; $display("FAIL bypass_hold: got v=%b out=%h want 0/4000", sample_valid_out, sample_out); end
    checks++; if (lfo_out !== 8'd255) begin errors++; $display("FAIL bypass_lfo: got %0d want 255", lfo_out); end
  endtask

  task automatic test_triangle();
    do_reset();
    en = 1'b1;
    tick();
    checks++; if (lfo_out !== 8'd254) begin errors++; $display("FAIL tri_first: got %0d want 254", lfo_out); end
    repeat (254) tick();
    checks++; if (lfo_out !== 8'd0) begin errors++; $display("FAIL tri_bottom: got %0d want 0", lfo_out); end
    tick();
    checks++; if (lfo_out !== 8'd1) begin errors++; $display("FAIL tri_turn: got %0d want 1", lfo_out); end
    @(negedge clk) clkdiv = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (lfo_out !== 8'd2) begin errors++; $display("FAIL tri_held_high: got %0d want 2", lfo_out); end
    clkdiv = 1'b0;
  endtask

  task automatic test_max_depth();
    logic [3:0]  dv [7] = '{4'd15, 4'd15, 4'd15, 4'd8, 4'd8, 4'd0, 4'd0};
    logic [15:0] sv [7] = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'h4000, 16'hFF00, 16'h7FFF, 16'h8000};
    logic [15:0] ev [7] = '{16'h087F, 16'hF780, 16'hFFFF, 16'h2040, 16'hFF7F, 16'h7FFF, 16'h8000};
    do_reset();
    en = 1'b1;
    repeat (255) tick();
    checks++; if (lfo_out !== 8'd0) begin errors++; $display("FAIL depth_lfo0: got %0d want 0", lfo_out); end
    for (int i = 0; i < 7; i++) begin
      depth = dv[i];
      drive_sample(sv[i]);
      checks++; if (sample_valid_out !== 1'b1 || sample_out !== ev[i]) begin
        errors++; $display("FAIL depth_vec[%0d]: got v=%b out=%h want 1/%h", i, sample_valid_out, sample_out, ev[i]);
      end
    end
  endtask

  task automatic test_streaming();
    logic [15:0] exp_q [20];
    logic [15:0] s;
    depth = 4'd15;
    // LFO sits at 0 (gain 17) until the tick on sample 10 moves it to 1 (gain 18).
    for (int i = 0; i < 20; i++) begin
      s = 16'h1000 + 16'(i * 256);
      exp_q[i] = 16'((int'(s) * ((i <= 10) ? 17 : 18)) >>> 8);
    end
    for (int k = 0; k < 23; k++) begin
      @(negedge clk);
      if (k >= 2 && k < 22) begin
        checks++; if (sample_valid_out !== 1'b1 || sample_out !== exp_q[k-2]) begin
          errors++; $display("FAIL stream[%0d]: got v=%b out=%h want 1/%h", k-2, sample_valid_out, sample_out, exp_q[k-2]);
        end
      end else if (k == 22) begin
        checks++; if (sample_valid_out !== 1'b0) begin errors++; $display("FAIL stream_end_valid: got %b want 0", sample_valid_out); end
      end
      clkdiv = (k == 10);
      if (k < 20) begin
        sample_in = 16'h1000 + 16'(k * 256);
        sample_valid_in = 1'b1;
      end else begin
        sample_valid_in = 1'b0;
      end
    end
    checks++; if (lfo_out !== 8'd1) begin errors++; $display("FAIL stream_lfo: got %0d want 1", lfo_out); end
  endtask

  task automatic test_midstream_reset();
    @(negedge clk);
    sample_in = 16'h1111; sample_valid_in = 1'b1;
    @(negedge clk);
    sample_valid_in = 1'b0; rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (sample_valid_out !== 1'b0) begin errors++; $display("FAIL midrst_valid[%0d]: got %b want 0", i, sample_valid_out); end
      @(negedge clk);
    end
    checks++; if (lfo_out !== 8'd255) begin errors++; $display("FAIL midrst_lfo: got %0d want 255", lfo_out); end
    tick();
    checks++; if (lfo_out !== 8'd254) begin errors++; $display("FAIL midrst_resume_lfo: got %0d want 254", lfo_out); end
    depth = 4'd0;
    drive_sample(16'h2222);
    checks++; if (sample_valid_out !== 1'b1 || sample_out !== 16'h2222) begin
      errors++; $display("FAIL midrst_resume_out: got v=%b out=%h want 1/2222", sample_valid_out, sample_out);
    end
  endtask

  initial begin
    rst = 1'b1; clkdiv = 1'b0; en = 1'b0; depth = 4'd0;
    sample_in = 16'd0; sample_valid_in = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_bypass();
    test_triangle();
    test_max_depth();
    test_streaming();
    test_midstream_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
